// File: rtl/dmem_responder.sv
// Data-port responder: synchronous data RAM plus an MMIO page with an output
// FIFO, a free-running cycle counter with snapshot read, and an LED register.
module dmem_responder #(
    parameter int unsigned AddrWidth = 8,
    parameter int unsigned FifoDepth = 4,
    parameter logic [15:0] IoBase    = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_addr,
    input  logic [15:0] w_data,
    input  logic        d_we,
    output logic [15:0] r_data,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] led
);

    localparam int unsigned RamWords = 2 ** AddrWidth;
    localparam int unsigned PtrW     = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW     = PtrW + 1;

    localparam logic [7:0] OffStatus = 8'h00;
    localparam logic [7:0] OffTxData = 8'h01;
    localparam logic [7:0] OffCntLo  = 8'h02;
    localparam logic [7:0] OffCntHi  = 8'h03;
    localparam logic [7:0] OffLed    = 8'h04;

    logic [15:0]      ram_q  [RamWords];
    logic [15:0]      fifo_q [FifoDepth];

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [15:0]      snap_q, snap_d;
    logic [15:0]      led_q, led_d;
    logic [15:0]      rdata_q, rdata_d;

    logic                 ram_hit_c;
    logic                 io_hit_c;
    logic [AddrWidth-1:0] ram_idx_c;
    logic [7:0]           off_c;
    logic                 full_c;
    logic                 empty_c;
    logic                 push_c;
    logic                 push_ok_c;
    logic                 pop_c;

    // Address decode; the RAM region takes priority should the two ever overlap.
    assign ram_hit_c = (32'(d_addr) < 32'(RamWords));
    assign io_hit_c  = (d_addr[15:8] == IoBase[15:8]);
    assign ram_idx_c = d_addr[AddrWidth-1:0];
    assign off_c     = d_addr[7:0];

    // Full is judged on the pre-pop occupancy, so a push into a full FIFO is
    // dropped even when the consumer frees a slot on the same edge.
    assign full_c    = (count_q == CntW'(FifoDepth));
    assign empty_c   = (count_q == '0);
    assign push_c    = d_we & io_hit_c & ~ram_hit_c & (off_c == OffTxData);
    assign push_ok_c = push_c & ~full_c;
    assign pop_c     = ~empty_c & out_ready;

    always_comb begin
        rdata_d  = '0;
        ovf_d    = ovf_q;
        snap_d   = snap_q;
        led_d    = led_q;
        cnt_d    = cnt_q + 32'd1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (ram_hit_c) begin
            rdata_d = ram_q[ram_idx_c];
        end else if (io_hit_c) begin
            unique case (off_c)
                OffStatus: begin
                    rdata_d = {13'b0, ovf_q, full_c, empty_c};
                    ovf_d   = 1'b0;
                end
                OffCntLo: begin
                    rdata_d = cnt_q[15:0];
                    snap_d  = cnt_q[31:16];
                end
                OffCntHi: rdata_d = snap_q;
                OffLed: begin
                    rdata_d = led_q;
                    if (d_we) begin
                        led_d = w_data;
                    end
                end
                default: rdata_d = '0;
            endcase
        end

        if (push_c && full_c) begin
            ovf_d = 1'b1;
        end
        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push_ok_c, pop_c})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            snap_q   <= '0;
            led_q    <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            led_q    <= led_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage arrays keep their contents across reset; FIFO occupancy is what gets cleared.
    always_ff @(posedge clk) begin
        if (d_we && ram_hit_c) begin
            ram_q[ram_idx_c] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            fifo_q[wr_ptr_q] <= w_data;
        end
    end

    assign r_data    = rdata_q;
    assign led       = led_q;
    assign out_valid = ~empty_c;
    assign out_data  = empty_c ? 16'h0000 : fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a transaction-level model predicts read
// data and FIFO output beats; monitors compare whatever the DUT presents.
module tb_dmem_responder;

    localparam int unsigned FifoDepth = 4;
    localparam logic [15:0] IoBase    = 16'hFF00;
    localparam logic [15:0] Idle      = 16'h0200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d_addr = Idle;
    logic [15:0] w_data = '0;
    logic        d_we = 1'b0;
    logic [15:0] r_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] led;

    dmem_responder #(
        .AddrWidth(8),
        .FifoDepth(FifoDepth),
        .IoBase   (IoBase)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .d_addr   (d_addr),
        .w_data   (w_data),
        .d_we     (d_we),
        .r_data   (r_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .led      (led)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk;
        logic [15:0] val;
        logic [15:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_out[$];

    // Reference state of the memory system as seen by software
    logic [15:0] m_ram [logic [15:0]];
    logic [15:0] m_fifo[$];
    logic        m_ovf;
    logic [31:0] m_cnt;
    logic [15:0] m_snap;
    logic [15:0] m_led;

    int errors = 0;
    int checks = 0;
    exp_t mon_e;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_ovf  = 1'b0;
        m_cnt  = '0;
        m_snap = '0;
        m_led  = '0;
    endtask

    // One bus transaction: drive, predict the edge, then step past it.
    task automatic cycle(input logic [15:0] a, input logic [15:0] wd, input logic we, input logic rdy);
        exp_t e;
        logic full;
        logic empty;
        logic push;
        logic pop;
        d_addr    = a;
        w_data    = wd;
        d_we      = we;
        out_ready = rdy;
        check16("led", led, m_led);
        check16("out_valid", 16'(out_valid), 16'(m_fifo.size() != 0));
        if (m_fifo.size() == 0) check16("out_data_empty", out_data, 16'h0000);

        full   = (m_fifo.size() == FifoDepth);
        empty  = (m_fifo.size() == 0);
        e.addr = a;
        e.chk  = 1'b1;
        e.val  = '0;
        if (a < 16'h0100) begin
            if (m_ram.exists(a)) e.val = m_ram[a];
            else e.chk = 1'b0;
            if (we) m_ram[a] = wd;
        end else if (a[15:8] == IoBase[15:8]) begin
            case (a[7:0])
                8'h00: begin e.val = {13'b0, m_ovf, full, empty}; m_ovf = 1'b0; end
                8'h02: begin e.val = m_cnt[15:0]; m_snap = m_cnt[31:16]; end
                8'h03: e.val = m_snap;
                8'h04: begin e.val = m_led; if (we) m_led = wd; end
                default: e.val = '0;
            endcase
        end
        push = we && (a == IoBase + 16'd1);
        pop  = !empty && rdy;
        if (push && full) m_ovf = 1'b1;
        if (pop) void'(m_fifo.pop_front());
        if (push && !full) begin
            m_fifo.push_back(wd);
            exp_out.push_back(wd);
        end
        m_cnt = m_cnt + 32'd1;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic async_reset();
        #4;
        rst  = 1'b1;
        d_we = 1'b0;
        exp_q.delete();
        exp_out.delete();
        #1;
        check16("rst_out_valid", 16'(out_valid), 16'h0000);
        check16("rst_led", led, 16'h0000);
        check16("rst_r_data", r_data, 16'h0000);
        check16("rst_out_data", out_data, 16'h0000);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst       = 1'b0;
        d_addr    = Idle;
        out_ready = 1'b0;
    endtask

    // Read-data monitor: one prediction per clock edge
    always @(posedge clk) begin
        #1;
        if (!rst && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk) check16($sformatf("r_data@%04h", mon_e.addr), r_data, mon_e.val);
        end
    end

    // Output-port monitor: a beat transfers on the coming edge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_out.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_beat: got 0x%04h expected no beat", out_data);
            end else begin
                check16("out_beat", out_data, exp_out.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check16("reset_r_data", r_data, 16'h0000);
        check16("reset_led", led, 16'h0000);
        check16("reset_out_valid", 16'(out_valid), 16'h0000);
        check16("reset_out_data", out_data, 16'h0000);
        rst = 1'b0;

        // RAM read-first and unmapped address
        cycle(16'h0010, 16'h1234, 1'b1, 1'b0);
        cycle(16'h0010, 16'hBEEF, 1'b1, 1'b0);
        cycle(16'h0010, 16'h0000, 1'b0, 1'b0);
        cycle(16'h0200, 16'h5555, 1'b1, 1'b0);
        cycle(16'h0200, 16'h0000, 1'b0, 1'b0);

        // FIFO fill, overflow, sticky flag clear, ordered drain
        for (int i = 1; i <= 4; i++) cycle(IoBase + 16'd1, 16'h00A0 + 16'(i), 1'b1, 1'b0);
        cycle(IoBase, 16'h0000, 1'b0, 1'b0);
        cycle(IoBase + 16'd1, 16'h00A5, 1'b1, 1'b0);
        cycle(IoBase, 16'h0000, 1'b0, 1'b0);
        cycle(IoBase, 16'h0000, 1'b0, 1'b0);
        repeat (6) cycle(Idle, 16'h0000, 1'b0, 1'b1);
        cycle(IoBase, 16'h0000, 1'b0, 1'b0);

        // Simultaneous push and pop with one entry held
        cycle(IoBase + 16'd1, 16'h0011, 1'b1, 1'b0);
        cycle(IoBase + 16'd1, 16'h0055, 1'b1, 1'b1);
        cycle(IoBase, 16'h0000, 1'b0, 1'b0);
        cycle(Idle, 16'h0000, 1'b0, 1'b1);

        // Full plus pop plus push: push dropped, overflow set
        for (int i = 0; i < 4; i++) cycle(IoBase + 16'd1, 16'h0070 + 16'(i), 1'b1, 1'b0);
        cycle(IoBase + 16'd1, 16'h0099, 1'b1, 1'b1);
        cycle(IoBase, 16'h0000, 1'b0, 1'b0);
        repeat (5) cycle(Idle, 16'h0000, 1'b0, 1'b1);

        // LED write/readback; write to a read-only offset is ignored
        cycle(IoBase + 16'd4, 16'h00FF, 1'b1, 1'b0);
        cycle(IoBase + 16'd4, 16'h0000, 1'b0, 1'b0);
        cycle(IoBase + 16'd2, 16'h1234, 1'b1, 1'b0);
        cycle(IoBase + 16'd4, 16'h0000, 1'b0, 1'b0);

        // Randomized traffic across RAM, MMIO and unmapped space
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a;
            case ($urandom_range(0, 5))
                0, 1:    a = 16'h0010 + 16'($urandom_range(0, 15));
                2:       a = IoBase + 16'($urandom_range(0, 7));
                3:       a = IoBase + 16'd1;
                4:       a = ($urandom_range(0, 1) != 0) ? 16'h0200 : 16'h8000;
                default: a = IoBase;
            endcase
            cycle(a, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
        end

        // Async reset with live FIFO contents, LED set and non-zero read data
        repeat (6) cycle(Idle, 16'h0000, 1'b0, 1'b1);
        cycle(16'h0020, 16'hCAFE, 1'b1, 1'b0);
        cycle(IoBase + 16'd4, 16'h00FF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(IoBase + 16'd1, 16'h00C0 + 16'(i), 1'b1, 1'b0);
        cycle(IoBase + 16'd4, 16'h0000, 1'b0, 1'b0);
        async_reset();
        cycle(16'h0020, 16'h0000, 1'b0, 1'b0);
        cycle(IoBase, 16'h0000, 1'b0, 1'b0);

        // Counter snapshot across the 16-bit boundary, started from reset
        async_reset();
        repeat (32'h1_0005) cycle(Idle, 16'h0000, 1'b0, 1'b0);
        cycle(IoBase + 16'd2, 16'h0000, 1'b0, 1'b0);
        cycle(IoBase + 16'd3, 16'h0000, 1'b0, 1'b0);
        cycle(IoBase + 16'd3, 16'h0000, 1'b0, 1'b0);

        repeat (3) cycle(Idle, 16'h0000, 1'b0, 1'b1);
        check16("beats_outstanding", 16'(exp_out.size()), 16'h0000);
        check16("reads_outstanding", 16'(exp_q.size()), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
